// File: rtl/bus_gpio_pkg.sv
// bus_gpio_pkg: register offsets, FSM states and field widths for bus_gpio_resp
package bus_gpio_pkg;
  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_SW     = 8'h04;
  localparam logic [7:0] OFF_KEY    = 8'h08;
  localparam logic [7:0] OFF_TIMER  = 8'h0C;
  localparam logic [7:0] OFF_CMP    = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;
  localparam logic [7:0] OFF_IRQ_EN = 8'h18;
  localparam int LED_W = 8;
  localparam int SW_W  = 4;
  localparam int KEY_W = 2;
  typedef enum logic {IDLE, RESP} state_t;
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchronizer plus stability counter for one active-low key
module key_debounce #(
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_in,
  output logic key_db
);
  localparam logic [19:0] LAST = DEBOUNCE_CYCLES - 20'd1;
  logic        key_meta, key_sync;
  logic [19:0] cnt;
  // sync the raw key, then flip key_db once the pressed level has been stable long enough
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_meta <= 1'b1;
      key_sync <= 1'b1;
      cnt      <= '0;
      key_db   <= 1'b0;
    end else begin
      key_meta <= key_in;
      key_sync <= key_meta;
      if (~key_sync == key_db) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        key_db <= ~key_db;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 20'd1;
      end
    end
  end
endmodule

// File: rtl/bus_gpio_resp.sv
// bus_gpio_resp: GPIO/timer responder on the valid/ready bus; BUS_GPIO_IRQ_EN adds irq and IRQ_EN at 0x18
module bus_gpio_resp
  import bus_gpio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h4000_0000,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd500000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_wstrb,
  output logic              mem_ready,
  output logic [31:0]       mem_rdata,
  input  logic [SW_W-1:0]   sw_in,
  input  logic [KEY_W-1:0]  key_in,
  output logic [LED_W-1:0]  led_out
`ifdef BUS_GPIO_IRQ_EN
  ,
  output logic              irq
`endif
);
  state_t            state;
  logic              sel, wr, match;
  logic [7:0]        off;
  logic [31:0]       timer, cmp, rd;
  logic [SW_W-1:0]   sw_meta, sw_sync;
  logic [KEY_W-1:0]  key_db;
`ifdef BUS_GPIO_IRQ_EN
  logic              irq_en;
`endif
  assign sel       = mem_valid && mem_addr[31:8] == BASE_ADDR[31:8];
  assign off       = mem_addr[7:0];
  assign wr        = state == IDLE && sel && mem_we;
  assign mem_ready = state == RESP;
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (.clk(clk), .rst(rst), .key_in(key_in[0]), .key_db(key_db[0]));
  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (.clk(clk), .rst(rst), .key_in(key_in[1]), .key_db(key_db[1]));
  // two-flop synchronizer for the slide switches
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= sw_in;
      sw_sync <= sw_meta;
    end
  end
  // read mux over the current register values; unmapped offsets read as zero
  always_comb begin
    rd = off == OFF_LED    ? {{(32-LED_W){1'b0}}, led_out} :
         off == OFF_SW     ? {{(32-SW_W){1'b0}}, sw_sync} :
         off == OFF_KEY    ? {{(32-KEY_W){1'b0}}, key_db} :
         off == OFF_TIMER  ? timer :
         off == OFF_CMP    ? cmp :
         off == OFF_STATUS ? {31'b0, match} : 32'b0;
`ifdef BUS_GPIO_IRQ_EN
    if (off == OFF_IRQ_EN) rd = {31'b0, irq_en};
`endif
  end
  // LED, timer, compare and sticky match; a store clears the timer, a match beats a status clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_out <= '0;
      timer   <= '0;
      cmp     <= '1;
      match   <= 1'b0;
    end else begin
      if (wr && off == OFF_LED && mem_wstrb[0]) led_out <= mem_wdata[LED_W-1:0];
      timer <= (wr && off == OFF_TIMER) ? 32'd0 : timer + 32'd1;
      for (int i = 0; i < 4; i++)
        if (wr && off == OFF_CMP && mem_wstrb[i]) cmp[8*i +: 8] <= mem_wdata[8*i +: 8];
      match <= (timer == cmp) || (match && !(wr && off == OFF_STATUS && mem_wstrb[0] && mem_wdata[0]));
    end
  end
  // one wait state: capture read data in IDLE, present it with mem_ready during RESP
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mem_rdata <= '0;
    end else if (state == IDLE && sel) begin
      state     <= RESP;
      mem_rdata <= rd;
    end else begin
      state     <= IDLE;
      mem_rdata <= '0;
    end
  end
`ifdef BUS_GPIO_IRQ_EN
  // interrupt enable register and registered interrupt output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (wr && off == OFF_IRQ_EN && mem_wstrb[0]) irq_en <= mem_wdata[0];
      irq <= match & irq_en;
    end
  end
`endif
endmodule

// File: tb/tb_bus_gpio_resp.sv
// tb_bus_gpio_resp: directed bus transactions against bus_gpio_resp with hand-computed results
module tb_bus_gpio_resp;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_valid = 1'b0;
  logic        mem_we = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [3:0]  sw_in = '0;
  logic [1:0]  key_in = 2'b11;
  logic [7:0]  led_out;
`ifdef BUS_GPIO_IRQ_EN
  logic        irq;
`endif
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] rd;
  int          lat;
  logic [3:0]  rdy;

  bus_gpio_resp #(.DEBOUNCE_CYCLES(20'd8)) dut (
    .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .sw_in(sw_in), .key_in(key_in), .led_out(led_out)
`ifdef BUS_GPIO_IRQ_EN
    , .irq(irq)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // lat = negedges from request to mem_ready (-1 if it never came within 5 cycles)
  task automatic acc(input logic [31:0] a, input logic we, input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] r, output int l);
    @(negedge clk);
    mem_valid = 1'b1; mem_we = we; mem_addr = a; mem_wdata = d; mem_wstrb = s;
    l = -1;
    r = '0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (mem_ready) begin
        l = i;
        r = mem_rdata;
        break;
      end
    end
    @(posedge clk);
    #1;
    mem_valid = 1'b0; mem_we = 1'b0; mem_wstrb = '0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_led", {24'b0, led_out}, 32'd0);
    rst = 1'b0;
    acc(32'h4000_0010, 1'b0, 0, 4'h0, rd, lat);
    chk("rst_cmp", rd, 32'hFFFF_FFFF);
    acc(32'h4000_0014, 1'b0, 0, 4'h0, rd, lat);
    chk("rst_status", rd, 32'd0);

    acc(32'h4000_0000, 1'b1, 32'h0000_00A5, 4'b0001, rd, lat);
    chk("led_wr_lat", lat, 32'd1);
    chk("led_out", {24'b0, led_out}, 32'h0000_00A5);
    acc(32'h4000_0000, 1'b0, 0, 4'h0, rd, lat);
    chk("led_rd", rd, 32'h0000_00A5);
    acc(32'h4000_0000, 1'b1, 32'h0000_003C, 4'b0000, rd, lat);
    chk("led_nostrb", {24'b0, led_out}, 32'h0000_00A5);

    sw_in = 4'b1010;
    repeat (3) @(negedge clk);
    acc(32'h4000_0004, 1'b0, 0, 4'h0, rd, lat);
    chk("sw_rd", rd, 32'h0000_000A);

    @(negedge clk); key_in = 2'b10;
    repeat (5) @(negedge clk);
    key_in = 2'b11;
    repeat (20) @(negedge clk);
    acc(32'h4000_0008, 1'b0, 0, 4'h0, rd, lat);
    chk("key_glitch", rd, 32'd0);
    @(negedge clk); key_in = 2'b10;
    repeat (3) @(negedge clk);
    acc(32'h4000_0008, 1'b0, 0, 4'h0, rd, lat);
    chk("key_early", rd, 32'd0);
    repeat (8) @(negedge clk);
    acc(32'h4000_0008, 1'b0, 0, 4'h0, rd, lat);
    chk("key_pressed", rd, 32'd1);
    key_in = 2'b11;
    repeat (14) @(negedge clk);
    acc(32'h4000_0008, 1'b0, 0, 4'h0, rd, lat);
    chk("key_released", rd, 32'd0);

    acc(32'h4000_000C, 1'b1, 32'h1234_5678, 4'hF, rd, lat);
    acc(32'h4000_000C, 1'b0, 0, 4'h0, rd, lat);
    chk("timer_clr", rd, 32'd1);
    acc(32'h4000_000C, 1'b0, 0, 4'h0, rd, lat);
    chk("timer_inc", rd, 32'd3);

    acc(32'h4000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, rd, lat);
    acc(32'h4000_0010, 1'b1, 32'h1122_3344, 4'b0101, rd, lat);
    acc(32'h4000_0010, 1'b0, 0, 4'h0, rd, lat);
    chk("cmp_bytes", rd, 32'hDE22_BE44);

    acc(32'h4000_0010, 1'b1, 32'd20, 4'hF, rd, lat);
    acc(32'h4000_0014, 1'b1, 32'd1, 4'b0001, rd, lat);
    acc(32'h4000_000C, 1'b1, 32'd0, 4'hF, rd, lat);
    acc(32'h4000_0014, 1'b0, 0, 4'h0, rd, lat);
    chk("match_before", rd, 32'd0);
    repeat (25) @(negedge clk);
    acc(32'h4000_0014, 1'b0, 0, 4'h0, rd, lat);
    chk("match_set", rd, 32'd1);
    acc(32'h4000_0014, 1'b1, 32'd1, 4'b0001, rd, lat);
    acc(32'h4000_0014, 1'b0, 0, 4'h0, rd, lat);
    chk("match_clr", rd, 32'd0);

    acc(32'h4000_0010, 1'b1, 32'd1, 4'hF, rd, lat);
    acc(32'h4000_000C, 1'b1, 32'd0, 4'hF, rd, lat);
    acc(32'h4000_0014, 1'b1, 32'd1, 4'b0001, rd, lat);
    acc(32'h4000_0014, 1'b0, 0, 4'h0, rd, lat);
    chk("match_set_wins", rd, 32'd1);

    acc(32'h5000_0000, 1'b1, 32'h0000_0077, 4'hF, rd, lat);
    chk("oow_lat", lat, 32'hFFFF_FFFF);
    chk("oow_led", {24'b0, led_out}, 32'h0000_00A5);
    acc(32'h4000_003C, 1'b1, 32'hFFFF_FFFF, 4'hF, rd, lat);
    acc(32'h4000_003C, 1'b0, 0, 4'h0, rd, lat);
    chk("unmap_lat", lat, 32'd1);
    chk("unmap_rd", rd, 32'd0);
    acc(32'h4000_0018, 1'b0, 0, 4'h0, rd, lat);
    chk("off18_rd", rd, 32'd0);

    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000_0000;
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      rdy[i] = mem_ready;
      if (i == 3) chk("b2b_rd", mem_rdata, 32'h0000_00A5);
    end
    mem_valid = 1'b0;
    chk("b2b_ready", {28'b0, rdy}, 32'h0000_000A);

    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b0; mem_addr = 32'h4000_0000;
    @(negedge clk);
    chk("pre_rst_ready", {31'b0, mem_ready}, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", {31'b0, mem_ready}, 32'd0);
    chk("mid_rst_rdata", mem_rdata, 32'd0);
    chk("mid_rst_led", {24'b0, led_out}, 32'd0);
    mem_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    acc(32'h4000_000C, 1'b0, 0, 4'h0, rd, lat);
    chk("post_rst_timer", rd, 32'd1);
    acc(32'h4000_0010, 1'b0, 0, 4'h0, rd, lat);
    chk("post_rst_cmp", rd, 32'hFFFF_FFFF);
    acc(32'h4000_0000, 1'b1, 32'h0000_003C, 4'b0001, rd, lat);
    chk("post_rst_lat", lat, 32'd1);
    acc(32'h4000_0000, 1'b0, 0, 4'h0, rd, lat);
    chk("post_rst_led", rd, 32'h0000_003C);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
